// File: rtl/rom_download_packer_if.sv
// Signal bundle between the hps_io ROM download port and the SDRAM write port.
// The packer uses the slave modport; whatever drives downloads and acks uses master.
interface rom_download_packer_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [19:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic [22:0] sdram_addr;
    logic [31:0] sdram_data;
    logic        sdram_we;
    logic        sdram_req;
    logic        sdram_ack;

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_data, sdram_ack,
        output sdram_addr, sdram_data, sdram_we, sdram_req
    );

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_data, sdram_ack,
        input  sdram_addr, sdram_data, sdram_we, sdram_req
    );
endinterface

// File: rtl/rom_download_packer.sv
// Packs the byte-wide hps_io ROM download into 32-bit SDRAM writes through a small word FIFO.
// Optional feature: define ROM_CHECKSUM_EN to generate the running byte checksum.
module rom_download_packer #(
    parameter logic [22:0] BASE_ADDR  = 23'd0,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    rom_download_packer_if.slave bus,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [31:0]          checksum
);
    localparam int             PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic             dlPrev_q;
    logic [22:0]      accAddr_q, accAddr_d;
    logic [31:0]      accData_q, accData_d;
    logic [3:0]       accMask_q, accMask_d;
    logic             accFull_q, accFull_d;
    logic             overflow_q, overflow_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [22:0]      memAddr [FIFO_DEPTH];
    logic [31:0]      memData [FIFO_DEPTH];

    logic        dlRise;
    logic        accept;
    logic [1:0]  lane;
    logic [22:0] byteAddr;
    logic        accNonEmpty;
    logic        newWord;
    logic        pushReq;
    logic        fifoEmpty;
    logic        fifoFull;
    logic        pop;
    logic        doPush;
    logic        dropWord;

    assign dlRise      = bus.ioctl_download & ~dlPrev_q;
    assign accept      = bus.ioctl_wr & bus.ioctl_download & (state_q == S_LOAD);
    assign lane        = bus.ioctl_addr[1:0];
    assign byteAddr    = BASE_ADDR + {4'd0, bus.ioctl_addr[19:2], 1'b0};
    assign accNonEmpty = |accMask_q;
    assign newWord     = accept & accNonEmpty & (byteAddr != accAddr_q);

    // A completed word always pushes one cycle after its lane-3 byte, which is why strobes must be spaced.
    assign pushReq = accFull_q | newWord | ((state_q == S_FLUSH) & accNonEmpty);

    assign fifoEmpty = (count_q == '0);
    assign fifoFull  = (count_q == FULL_CNT);
    assign pop       = bus.sdram_ack & ~fifoEmpty;
    assign doPush    = pushReq & (~fifoFull | pop);
    assign dropWord  = pushReq & fifoFull & ~pop;

    assign bus.sdram_req  = ~fifoEmpty;
    assign bus.sdram_we   = ~fifoEmpty;
    assign bus.sdram_addr = fifoEmpty ? 23'd0 : memAddr[rdPtr_q];
    assign bus.sdram_data = fifoEmpty ? 32'd0 : memData[rdPtr_q];
    assign overflow       = overflow_q;

    always_comb begin
        accAddr_d  = accAddr_q;
        accData_d  = accData_q;
        accMask_d  = accMask_q;
        accFull_d  = accFull_q;
        overflow_d = overflow_q;
        if (pushReq) begin
            accData_d = 32'd0;
            accMask_d = 4'd0;
            accFull_d = 1'b0;
        end
        if (dlRise) begin
            accData_d  = 32'd0;
            accMask_d  = 4'd0;
            accFull_d  = 1'b0;
            overflow_d = 1'b0;
        end else if (dropWord) begin
            overflow_d = 1'b1;
        end
        if (accept) begin
            accAddr_d                     = byteAddr;
            accData_d[{lane, 3'b000} +: 8] = bus.ioctl_data;
            accMask_d[lane]               = 1'b1;
            if (lane == 2'd3) begin
                accFull_d = 1'b1;
            end
        end
    end

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({doPush, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // A new download edge during drain restarts loading while the FIFO keeps emptying.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dlRise) state_d = S_LOAD;
            end
            S_LOAD: begin
                busy = 1'b1;
                if (!bus.ioctl_download) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                busy    = 1'b1;
                state_d = dlRise ? S_LOAD : S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (dlRise) begin
                    state_d = S_LOAD;
                end else if (count_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = dlRise ? S_LOAD : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            dlPrev_q   <= 1'b0;
            accAddr_q  <= 23'd0;
            accData_q  <= 32'd0;
            accMask_q  <= 4'd0;
            accFull_q  <= 1'b0;
            overflow_q <= 1'b0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            dlPrev_q   <= bus.ioctl_download;
            accAddr_q  <= accAddr_d;
            accData_q  <= accData_d;
            accMask_q  <= accMask_d;
            accFull_q  <= accFull_d;
            overflow_q <= overflow_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (doPush) begin
            memAddr[wrPtr_q] <= accAddr_q;
            memData[wrPtr_q] <= accData_q;
        end
    end

`ifdef ROM_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (dlRise) begin
            sum_d = 32'd0;
        end else if (accept) begin
            sum_d = sum_q + {24'd0, bus.ioctl_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= 32'd0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 32'd0;
`endif
endmodule

// File: tb/tb_rom_download_packer.sv
// Self-checking bench for rom_download_packer: a byte-stream word model predicts every SDRAM write,
// with hand-computed literals for reset, latency, flush, overflow, word-change and checksum cases.
module tb_rom_download_packer;
    localparam int          DEPTH = 4;
    localparam logic [22:0] BASE  = 23'd0;

    typedef struct packed {
        logic [22:0] addr;
        logic [31:0] data;
    } word_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [31:0] checksum;

    rom_download_packer_if bus();

    rom_download_packer #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    word_t       expQ[$];
    int          curWord     = -1;
    logic [31:0] curData     = 32'd0;
    logic [31:0] modelSum    = 32'd0;
    logic        expOverflow = 1'b0;
    logic        autoAck     = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual 0x%08h, required 0x%08h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] expectedSum(input logic [31:0] sum);
`ifdef ROM_CHECKSUM_EN
        return sum;
`else
        return 32'd0 & sum;
`endif
    endfunction

    // Model: bytes gather into words by word address; a word leaves on lane 3, on a word change, or at download end.
    function automatic void emitWord();
        word_t w;
        if (curWord < 0) return;
        if (expQ.size() >= DEPTH) begin
            expOverflow = 1'b1;
        end else begin
            w.addr = BASE + 23'(curWord * 2);
            w.data = curData;
            expQ.push_back(w);
        end
        curWord = -1;
        curData = 32'd0;
    endfunction

    function automatic void modelByte(input logic [19:0] addr, input logic [7:0] data);
        int w;
        int lane;
        if (!bus.ioctl_download) return;
        w    = int'(addr[19:2]);
        lane = int'(addr[1:0]);
        if (curWord >= 0 && w != curWord) emitWord();
        curWord = w;
        curData[lane*8 +: 8] = data;
        modelSum = modelSum + 32'(data);
        if (lane == 3) emitWord();
    endfunction

    task automatic applyStimulus(input logic [19:0] addr, input logic [7:0] data);
        modelByte(addr, data);
        bus.ioctl_addr = addr;
        bus.ioctl_data = data;
        bus.ioctl_wr   = 1'b1;
        @(posedge clk); #1;
        bus.ioctl_wr   = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic startDownload();
        bus.ioctl_download = 1'b1;
        curWord     = -1;
        curData     = 32'd0;
        modelSum    = 32'd0;
        expOverflow = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("busyInLoad", 32'(busy), 32'd1);
        checkOutput("overflowCleared", 32'(overflow), 32'd0);
        checkOutput("checksumCleared", checksum, 32'd0);
    endtask

    task automatic endDownload();
        bus.ioctl_download = 1'b0;
        emitWord();
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("overflowModel", 32'(overflow), 32'(expOverflow));
        checkOutput("checksumModel", checksum, expectedSum(modelSum));
    endtask

    task automatic ackAll(input bit expectDone);
        int n;
        autoAck = 1'b1;
        for (n = 0; n < 300; n++) begin
            @(posedge clk);
            if (expQ.size() == 0) break;
        end
        if (n == 300) checkOutput("drainTimeout", 32'(expQ.size()), 32'd0);
        autoAck = 1'b0;
        @(negedge clk);
        checkOutput("busyAfterDrain", 32'(busy), 32'd0);
        if (expectDone) begin
            checkOutput("donePulse", 32'(done), 32'd1);
            @(negedge clk);
            checkOutput("doneOneCycle", 32'(done), 32'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.sdram_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.sdram_ack = autoAck && bus.sdram_req;
        end
    end

    // Every cycle a request is up, it must match the oldest outstanding model word; an ack retires it.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (bus.sdram_req) begin
                    checkOutput("weWithReq", 32'(bus.sdram_we), 32'd1);
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedReq", 32'(bus.sdram_req), 32'd0);
                    end else begin
                        checkOutput("writeAddr", 32'(bus.sdram_addr), 32'(expQ[0].addr));
                        checkOutput("writeData", bus.sdram_data, expQ[0].data);
                        if (bus.sdram_ack) expQ.delete(0);
                    end
                end else begin
                    checkOutput("weWithoutReq", 32'(bus.sdram_we), 32'd0);
                end
            end
        end
    end

    initial begin
        #1000000;
        miscompares++;
        $display("[TB] FAIL globalTimeout: simulation did not finish in time");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        reset_n            = 1'b1;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = 20'd0;
        bus.ioctl_data     = 8'd0;
        #1 reset_n = 1'b0;
        #2;
        checkOutput("resetReq", 32'(bus.sdram_req), 32'd0);
        checkOutput("resetWe", 32'(bus.sdram_we), 32'd0);
        checkOutput("resetAddr", 32'(bus.sdram_addr), 32'd0);
        checkOutput("resetData", bus.sdram_data, 32'd0);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetDone", 32'(done), 32'd0);
        checkOutput("resetOverflow", 32'(overflow), 32'd0);
        checkOutput("resetChecksum", checksum, 32'd0);
        #9 reset_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] full word at addresses 0-3");
        startDownload();
        applyStimulus(20'h0, 8'h11);
        applyStimulus(20'h1, 8'h22);
        applyStimulus(20'h2, 8'h33);
        modelByte(20'h3, 8'h44);
        bus.ioctl_addr = 20'h3;
        bus.ioctl_data = 8'h44;
        bus.ioctl_wr   = 1'b1;
        @(posedge clk); #1;
        bus.ioctl_wr = 1'b0;
        checkOutput("reqBeforePush", 32'(bus.sdram_req), 32'd0);
        @(posedge clk); #1;
        checkOutput("reqAfterPush", 32'(bus.sdram_req), 32'd1);
        checkOutput("firstAddr", 32'(bus.sdram_addr), 32'h0);
        checkOutput("firstData", bus.sdram_data, 32'h44332211);
        endDownload();
        ackAll(1'b1);

        $display("[TB] strobe outside download window");
        applyStimulus(20'h3, 8'h99);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("idleStrobeBusy", 32'(busy), 32'd0);
        checkOutput("idleStrobeSum", checksum, expectedSum(32'h000000AA));

        $display("[TB] partial word flushed at download end");
        startDownload();
        applyStimulus(20'h104, 8'hAA);
        applyStimulus(20'h105, 8'hBB);
        endDownload();
        checkOutput("flushReq", 32'(bus.sdram_req), 32'd1);
        checkOutput("flushAddr", 32'(bus.sdram_addr), 32'h082);
        checkOutput("flushData", bus.sdram_data, 32'h0000BBAA);
        ackAll(1'b1);

        $display("[TB] five words into a four-deep FIFO with acks held");
        startDownload();
        for (int w = 0; w < 5; w++) begin
            if (w == 4) checkOutput("noOverflowAtFull", 32'(overflow), 32'd0);
            for (int b = 0; b < 4; b++) begin
                applyStimulus(20'(32'h200 + w * 4 + b), 8'(8'h30 + w * 4 + b));
            end
        end
        checkOutput("overflowSet", 32'(overflow), 32'd1);
        endDownload();
        ackAll(1'b1);
        checkOutput("overflowSticky", 32'(overflow), 32'd1);

        $display("[TB] byte for a new word behind a partial accumulator");
        startDownload();
        applyStimulus(20'h0, 8'h5A);
        applyStimulus(20'h1, 8'h6B);
        applyStimulus(20'h7, 8'hC3);
        checkOutput("oldWordAddr", 32'(bus.sdram_addr), 32'h0);
        checkOutput("oldWordData", bus.sdram_data, 32'h00006B5A);
        endDownload();
        ackAll(1'b1);

        $display("[TB] 256-byte stream with acks flowing");
        startDownload();
        autoAck = 1'b1;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(20'(32'h1000 + i), 8'(i));
        end
        endDownload();
        checkOutput("checksum256", checksum, expectedSum(32'h00007F80));
        ackAll(1'b0);

        $display("[TB] reset during drain");
        startDownload();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(20'(32'h40 + i), 8'(8'hE0 + i));
        end
        endDownload();
        checkOutput("reqBeforeReset", 32'(bus.sdram_req), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("asyncResetReq", 32'(bus.sdram_req), 32'd0);
        checkOutput("asyncResetWe", 32'(bus.sdram_we), 32'd0);
        checkOutput("asyncResetAddr", 32'(bus.sdram_addr), 32'd0);
        checkOutput("asyncResetBusy", 32'(busy), 32'd0);
        expQ.delete();
        curWord = -1;
        curData = 32'd0;
        @(posedge clk); #3;
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("postResetReq", 32'(bus.sdram_req), 32'd0);
        checkOutput("postResetBusy", 32'(busy), 32'd0);
        checkOutput("postResetDone", 32'(done), 32'd0);
        checkOutput("postResetChecksum", checksum, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
